arm_test_sequencer: RTL and testbench
=====================================

Name: arm_test_sequencer

Overview:
Test-round sequencer that stands in for the ARM host in front of the root hub of the distributed decoder.
After reset it waits a programmable settling period, then issues one-cycle new_round_start pulses, one per test case.
It waits for the decoder's result_valid before starting the next round and keeps a running 32-bit test-case ID.
It also flags rounds that time out and signals completion after a configured number of test cases.

Parameters:
reset_threshold, 32'd100, cycles to wait after reset release before the first round start.
INTER_ROUND_GAP, 4, idle cycles between end of one round and the next start (min 1).
MAX_TEST_CASES, 0, number of rounds to run; 0 means unlimited.
TIMEOUT_CYCLES, 0, max cycles spent waiting for result_valid per round; 0 disables the timeout.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-low reset.
result_valid  input  1  decoder result ready (level; may be held high for several cycles).
new_round_start  output  1  one-cycle pulse that starts a decoding round.
total_test_case_counter  output  32  ID of the current/most recent round (1-based).
round_timeout  output  1  one-cycle pulse when a round exceeds TIMEOUT_CYCLES.
done  output  1  high once MAX_TEST_CASES rounds have completed; sticky until reset.

Behaviour:
- All outputs are registered. On reset low at a clk edge: state=SETTLE, wait counter=0, new_round_start=0, total_test_case_counter=0, round_timeout=0, done=0.
- Reset asserted mid-round aborts the round and restarts from SETTLE.
- SETTLE: count cycles after reset release. After reset_threshold cycles, go to ARM. With reset_threshold=0, go to ARM on the first cycle.
- ARM: wait until result_valid==0; this prevents a held result from the prior round being counted twice. Then go to START.
- START (single cycle):
  - new_round_start=1 for exactly this cycle.
  - total_test_case_counter increments in the same edge, so it already shows the new ID while the pulse is high. First round ID = 1.
  - Clear the round wait counter. Go to WAIT.
- WAIT: the round completes on the first cycle with result_valid==1 (result_valid seen in the START cycle itself is ignored); go to GAP.
- WAIT timeout (TIMEOUT_CYCLES>0 and wait counter reaches TIMEOUT_CYCLES first): round_timeout=1 for one cycle; the round counts as completed; go to GAP.
- result_valid and timeout in the same cycle: result_valid wins; no round_timeout pulse.
- GAP: wait INTER_ROUND_GAP cycles.
  - If MAX_TEST_CASES!=0 and total_test_case_counter==MAX_TEST_CASES: go to DONE.
  - Otherwise: go to ARM.
- DONE: done=1; new_round_start held 0; result_valid ignored; stays until reset.
- total_test_case_counter wraps 0xFFFFFFFF→0 without error (only relevant when MAX_TEST_CASES=0).
- Wait counters are 32 bit and saturate; they never wrap within a state.
- Minimum start-to-start spacing: 1 (START) + ≥1 (WAIT) + INTER_ROUND_GAP + ≥1 (ARM) cycles.

Decomposition:
- Shared package: state enum (SETTLE, ARM, START, WAIT, GAP, DONE) and the 32-bit counter width constant.
- Single module; no sub-module needed. The down-counter/comparator logic is small enough to stay inline.

Test Plan:
- Reset low for 10 cycles, then high, reset_threshold=100, result_valid=0 → first new_round_start pulse exactly 100 cycles after release (+1 for ARM); counter=1 during the pulse; pulse width 1.
- Return result_valid=1 for 1 cycle 20 cycles after each start, INTER_ROUND_GAP=4 → next pulse 6 cycles after result (GAP 4 + ARM 1 + START); IDs 1,2,3 increase monotonically.
- Hold result_valid high for 10 cycles → exactly one round completion; next start only after result_valid returns low.
- TIMEOUT_CYCLES=50, result_valid never asserted → round_timeout pulses 50 cycles into WAIT; next round starts with ID incremented.
- MAX_TEST_CASES=3 → after the third result and the gap, done=1; no further new_round_start; counter stays 3.
- Assert reset during WAIT of round 2 → outputs return to 0 next edge; after the settle period the first pulse carries ID 1 again.

Source files
------------

// File: rtl/arm_test_sequencer_pkg.sv
// Shared types for the ARM test-round sequencer: FSM state encoding and
// the width of every counter in the block.
package arm_test_sequencer_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [2:0] {
      S_SETTLE = 3'd0,
      S_ARM    = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_GAP    = 3'd4,
      S_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/arm_test_sequencer_if.sv
// Round handshake between the sequencer (master, standing in for the ARM
// host) and the root hub of the distributed decoder (slave).
interface arm_test_sequencer_if;
   import arm_test_sequencer_pkg::*;

   logic             result_valid;
   logic             new_round_start;
   logic [CNT_W-1:0] total_test_case_counter;
   logic             round_timeout;
   logic             done;

   modport master (
      input  result_valid,
      output new_round_start,
      output total_test_case_counter,
      output round_timeout,
      output done
   );

   modport slave (
      output result_valid,
      input  new_round_start,
      input  total_test_case_counter,
      input  round_timeout,
      input  done
   );

endinterface

// File: rtl/arm_test_sequencer.sv
// Test-round sequencer: settles after reset, then launches one decoding
// round at a time, waits for the decoder result (or a timeout), idles for
// a gap and repeats until the configured number of rounds has run.
// A single saturating cycle counter is shared by all states; it restarts
// at zero on every state change, so within a state it is the 0-based
// index of the current cycle in that state.
module arm_test_sequencer
   import arm_test_sequencer_pkg::*;
#(
   parameter logic [CNT_W-1:0] reset_threshold = 32'd100,
   parameter int unsigned      INTER_ROUND_GAP = 4,
   parameter int unsigned      MAX_TEST_CASES  = 0,
   parameter int unsigned      TIMEOUT_CYCLES  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   arm_test_sequencer_if.master bus
);

   // Index of the last cycle spent in each timed state. Thresholds of 0
   // collapse onto index 0 so the state still lasts one cycle; a gap of 0
   // is treated as the minimum gap of 1.
   localparam logic [CNT_W-1:0] SETTLE_LAST  = (reset_threshold == '0) ? '0 : reset_threshold - 1'b1;
   localparam logic [CNT_W-1:0] GAP_LAST     = (INTER_ROUND_GAP <= 1) ? '0 : CNT_W'(INTER_ROUND_GAP - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_ID       = CNT_W'(MAX_TEST_CASES);
   localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam bit               LIMIT_EN     = (MAX_TEST_CASES != 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] case_id_q;
   logic             new_round_start_q;
   logic             round_timeout_q;
   logic             done_q;
   logic             timeout_fire;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Next-state logic; result_valid takes priority over the round timeout.
   always_comb begin
      state_d      = state_q;
      cnt_d        = sat_inc(cnt_q);
      timeout_fire = 1'b0;
      case (state_q)
         S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_ARM;
         // A result still held from the previous round must drop first.
         S_ARM:    if (!bus.result_valid) state_d = S_START;
         S_START:  state_d = S_WAIT;
         S_WAIT: begin
            if (bus.result_valid) begin
               state_d = S_GAP;
            end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
               state_d      = S_GAP;
               timeout_fire = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = (LIMIT_EN && (case_id_q == MAX_ID)) ? S_DONE : S_ARM;
            end
         end
         S_DONE:   state_d = S_DONE;
         default:  state_d = S_SETTLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // State register and shared cycle counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_SETTLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Registered outputs, derived from the next state so they line up with
   // the state they describe; the case ID advances on the START edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         new_round_start_q <= 1'b0;
         case_id_q         <= '0;
         round_timeout_q   <= 1'b0;
         done_q            <= 1'b0;
      end else begin
         new_round_start_q <= (state_d == S_START);
         if (state_d == S_START) case_id_q <= case_id_q + 1'b1;
         round_timeout_q   <= timeout_fire;
         done_q            <= (state_d == S_DONE);
      end
   end

   assign bus.new_round_start         = new_round_start_q;
   assign bus.total_test_case_counter = case_id_q;
   assign bus.round_timeout           = round_timeout_q;
   assign bus.done                    = done_q;

endmodule

// File: tb/tb_arm_test_sequencer.sv
// Directed bench for arm_test_sequencer. dut_a: settle 100, gap 4,
// unlimited rounds, timeout 50. dut_b: settle 5, gap 4, 3 rounds, no timeout.
// Inputs change 1 ns after a rising edge; outputs are read at the same point.
module tb_arm_test_sequencer;
   import arm_test_sequencer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   arm_test_sequencer_if bus_a ();
   arm_test_sequencer_if bus_b ();

   arm_test_sequencer #(
      .reset_threshold (32'd100),
      .INTER_ROUND_GAP (4),
      .MAX_TEST_CASES  (0),
      .TIMEOUT_CYCLES  (50)
   ) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a.master)
   );

   arm_test_sequencer #(
      .reset_threshold (32'd5),
      .INTER_ROUND_GAP (4),
      .MAX_TEST_CASES  (3),
      .TIMEOUT_CYCLES  (0)
   ) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b.master)
   );

   int checks   = 0;
   int failures = 0;
   int to_cnt_a = 0;
   int to_cnt_b = 0;
   int nrs_cnt_b = 0;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (bus_a.round_timeout === 1'b1) to_cnt_a++;
      if (bus_b.round_timeout === 1'b1) to_cnt_b++;
      if (bus_b.new_round_start === 1'b1) nrs_cnt_b++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until the selected output is high; n = edges taken, -1 if none.
   task automatic wait_sig(input int sel, input int limit, output int n);
      logic s;
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         case (sel)
            0:       s = bus_a.new_round_start;
            1:       s = bus_a.round_timeout;
            2:       s = bus_b.new_round_start;
            default: s = bus_b.done;
         endcase
         if (s === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b0;
      bus_a.result_valid = 1'b0;
      repeat (10) tick();
      checks++; if (bus_a.new_round_start !== 1'b0) begin failures++; $display("FAIL reset_nrs got=%b want=0", bus_a.new_round_start); end
      checks++; if (bus_a.total_test_case_counter !== 32'd0) begin failures++; $display("FAIL reset_counter got=%0d want=0", bus_a.total_test_case_counter); end
      checks++; if (bus_a.round_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", bus_a.round_timeout); end
      checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus_a.done); end
   endtask

   // Settle of 100 cycles plus one ARM cycle: pulse after the 101st edge.
   task automatic test_first_round();
      int n;
      rst_a = 1'b1;
      wait_sig(0, 300, n);
      checks++; if (n !== 101) begin failures++; $display("FAIL first_start_latency got=%0d want=101", n); end
      checks++; if (bus_a.total_test_case_counter !== 32'd1) begin failures++; $display("FAIL first_id got=%0d want=1", bus_a.total_test_case_counter); end
      tick();
      checks++; if (bus_a.new_round_start !== 1'b0) begin failures++; $display("FAIL first_pulse_width got=%b want=0", bus_a.new_round_start); end
   endtask

   // Result 20 cycles after each start; next start 5 edges after the
   // edge that sampled the result (GAP 4 + ARM 1).
   task automatic test_rounds();
      int n;
      int base;
      base = to_cnt_a;
      for (int id = 2; id <= 3; id++) begin
         repeat (18) tick();
         bus_a.result_valid = 1'b1;
         tick();
         bus_a.result_valid = 1'b0;
         wait_sig(0, 100, n);
         checks++; if (n !== 5) begin failures++; $display("FAIL round_spacing id=%0d got=%0d want=5", id, n); end
         checks++; if (bus_a.total_test_case_counter !== 32'(id)) begin failures++; $display("FAIL round_id got=%0d want=%0d", bus_a.total_test_case_counter, id); end
         tick();
         checks++; if (bus_a.new_round_start !== 1'b0) begin failures++; $display("FAIL round_pulse_width id=%0d got=%b want=0", id, bus_a.new_round_start); end
      end
      checks++; if (to_cnt_a !== base) begin failures++; $display("FAIL round_no_timeout got=%0d want=%0d", to_cnt_a, base); end
   endtask

   // Result held for 10 cycles: one completion, restart once it drops.
   task automatic test_held_result();
      int n;
      repeat (18) tick();
      bus_a.result_valid = 1'b1;
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (i == 10) bus_a.result_valid = 1'b0;
         if (bus_a.new_round_start === 1'b1) begin
            n = i;
            break;
         end
      end
      bus_a.result_valid = 1'b0;
      checks++; if (n !== 11) begin failures++; $display("FAIL held_restart got=%0d want=11", n); end
      checks++; if (bus_a.total_test_case_counter !== 32'd4) begin failures++; $display("FAIL held_id got=%0d want=4", bus_a.total_test_case_counter); end
      tick();
   endtask

   // No result: timeout pulse after 50 WAIT cycles, next round follows.
   task automatic test_timeout();
      int n;
      wait_sig(1, 100, n);
      checks++; if (n !== 50) begin failures++; $display("FAIL timeout_latency got=%0d want=50", n); end
      checks++; if (bus_a.total_test_case_counter !== 32'd4) begin failures++; $display("FAIL timeout_id_hold got=%0d want=4", bus_a.total_test_case_counter); end
      tick();
      checks++; if (bus_a.round_timeout !== 1'b0) begin failures++; $display("FAIL timeout_width got=%b want=0", bus_a.round_timeout); end
      wait_sig(0, 20, n);
      checks++; if (n !== 4) begin failures++; $display("FAIL timeout_restart got=%0d want=4", n); end
      checks++; if (bus_a.total_test_case_counter !== 32'd5) begin failures++; $display("FAIL timeout_next_id got=%0d want=5", bus_a.total_test_case_counter); end
      tick();
   endtask

   // Result arrives in the very cycle the timeout would fire: result wins.
   task automatic test_timeout_tie();
      int n;
      int base;
      base = to_cnt_a;
      repeat (49) tick();
      bus_a.result_valid = 1'b1;
      tick();
      bus_a.result_valid = 1'b0;
      checks++; if (bus_a.round_timeout !== 1'b0) begin failures++; $display("FAIL tie_timeout got=%b want=0", bus_a.round_timeout); end
      wait_sig(0, 20, n);
      checks++; if (n !== 5) begin failures++; $display("FAIL tie_restart got=%0d want=5", n); end
      checks++; if (bus_a.total_test_case_counter !== 32'd6) begin failures++; $display("FAIL tie_id got=%0d want=6", bus_a.total_test_case_counter); end
      checks++; if (to_cnt_a !== base) begin failures++; $display("FAIL tie_no_pulse got=%0d want=%0d", to_cnt_a, base); end
      tick();
   endtask

   // Reset in the middle of WAIT aborts the round; IDs restart at 1.
   task automatic test_reset_mid_wait();
      int n;
      repeat (10) tick();
      rst_a = 1'b0;
      tick();
      checks++; if (bus_a.total_test_case_counter !== 32'd0) begin failures++; $display("FAIL midrst_counter got=%0d want=0", bus_a.total_test_case_counter); end
      checks++; if (bus_a.new_round_start !== 1'b0) begin failures++; $display("FAIL midrst_nrs got=%b want=0", bus_a.new_round_start); end
      rst_a = 1'b1;
      wait_sig(0, 300, n);
      checks++; if (n !== 101) begin failures++; $display("FAIL midrst_latency got=%0d want=101", n); end
      checks++; if (bus_a.total_test_case_counter !== 32'd1) begin failures++; $display("FAIL midrst_id got=%0d want=1", bus_a.total_test_case_counter); end
   endtask

   // Three rounds then DONE; timeout disabled so a long wait is harmless.
   task automatic test_max_cases();
      int n;
      checks++; if (bus_b.done !== 1'b0) begin failures++; $display("FAIL b_reset_done got=%b want=0", bus_b.done); end
      rst_b = 1'b1;
      wait_sig(2, 50, n);
      checks++; if (n !== 6) begin failures++; $display("FAIL b_first_latency got=%0d want=6", n); end
      checks++; if (bus_b.total_test_case_counter !== 32'd1) begin failures++; $display("FAIL b_id1 got=%0d want=1", bus_b.total_test_case_counter); end
      repeat (80) tick();
      for (int id = 2; id <= 4; id++) begin
         bus_b.result_valid = 1'b1;
         tick();
         bus_b.result_valid = 1'b0;
         if (id <= 3) begin
            wait_sig(2, 20, n);
            checks++; if (n !== 5) begin failures++; $display("FAIL b_spacing id=%0d got=%0d want=5", id, n); end
            checks++; if (bus_b.total_test_case_counter !== 32'(id)) begin failures++; $display("FAIL b_id got=%0d want=%0d", bus_b.total_test_case_counter, id); end
            checks++; if (bus_b.done !== 1'b0) begin failures++; $display("FAIL b_early_done id=%0d got=%b want=0", id, bus_b.done); end
            repeat (3) tick();
         end
      end
      wait_sig(3, 20, n);
      checks++; if (n !== 4) begin failures++; $display("FAIL b_done_latency got=%0d want=4", n); end
      for (int i = 0; i < 30; i++) begin
         bus_b.result_valid = i[0];
         tick();
      end
      bus_b.result_valid = 1'b0;
      checks++; if (bus_b.done !== 1'b1) begin failures++; $display("FAIL b_done_sticky got=%b want=1", bus_b.done); end
      checks++; if (bus_b.total_test_case_counter !== 32'd3) begin failures++; $display("FAIL b_final_id got=%0d want=3", bus_b.total_test_case_counter); end
      checks++; if (nrs_cnt_b !== 3) begin failures++; $display("FAIL b_start_count got=%0d want=3", nrs_cnt_b); end
      checks++; if (to_cnt_b !== 0) begin failures++; $display("FAIL b_timeout_count got=%0d want=0", to_cnt_b); end
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      bus_a.result_valid = 1'b0;
      bus_b.result_valid = 1'b0;
      test_reset();
      test_first_round();
      test_rounds();
      test_held_result();
      test_timeout();
      test_timeout_tie();
      test_reset_mid_wait();
      test_max_cases();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
